// File: rtl/idli_sqi_mem_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_mem_m
// Brief    : SQI responder (serial quad SRAM, device end) with a byte array,
//            READ 0x03 / WRITE 0x02, 24-bit address, MSB-nibble-first.
//            Define IDLI_SQI_MEM_MODE_EN to add the WRMR/RDMR mode register.
// Revision : 1.0 - initial release
// ============================================================================
module idli_sqi_mem_m #(
    parameter int DEPTH = 1024
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    localparam int         C_AW          = $clog2(DEPTH);
    localparam logic [7:0] C_INSTR_READ  = 8'h03;
    localparam logic [7:0] C_INSTR_WRITE = 8'h02;
`ifdef IDLI_SQI_MEM_MODE_EN
    localparam logic [7:0] C_INSTR_WRMR  = 8'h01;
    localparam logic [7:0] C_INSTR_RDMR  = 8'h05;
    localparam logic [7:0] C_MODE_RESET  = 8'h40;
`endif

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INSTR   = 4'd1,
        ST_ADDR    = 4'd2,
        ST_DUMMY   = 4'd3,
        ST_RDATA   = 4'd4,
        ST_WDATA   = 4'd5,
        ST_IGNORE  = 4'd6,
        ST_MODE_WR = 4'd7,
        ST_MODE_RD = 4'd8
    } state_t;

    state_t      r_state, w_state_nx;
    logic        r_sck_q;
    logic [2:0]  r_cnt, w_cnt_nx;
    logic [19:0] r_shift, w_shift_nx;
    logic [23:0] r_addr, w_addr_nx, w_addr_inc;
    logic        r_is_read, w_is_read_nx;
    logic [3:0]  r_wbuf, w_wbuf_nx;
    logic        r_lo, w_lo_nx;
    logic [3:0]  r_sio, w_sio_nx;
    logic        r_oe, w_oe_nx;
    logic        w_mem_we;
    logic [7:0]  w_instr;
    logic [7:0]  w_rd_byte;
    logic        w_rise, w_fall;
    logic        w_byte_mode;

    logic [7:0]  r_mem [DEPTH];

    assign w_rise    = i_mem_sck & ~r_sck_q;
    assign w_fall    = ~i_mem_sck & r_sck_q;
    assign w_rd_byte = r_mem[r_addr[C_AW-1:0]];
    assign w_instr   = {r_shift[3:0], i_mem_sio};

`ifdef IDLI_SQI_MEM_MODE_EN
    logic [7:0] r_mode, w_mode_nx;

    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            r_mode <= C_MODE_RESET;
        end else begin
            r_mode <= w_mode_nx;
        end
    end

    assign w_byte_mode = (r_mode[7:6] == 2'b00);

    // Page mode keeps the upper address bits and wraps within 32 bytes
    always_comb begin
        w_addr_inc = r_addr + 24'd1;
        if (r_mode[7:6] == 2'b10) begin
            w_addr_inc = {r_addr[23:5], r_addr[4:0] + 5'd1};
        end
    end
`else
    assign w_byte_mode = 1'b0;
    assign w_addr_inc  = r_addr + 24'd1;
`endif

    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            r_state   <= ST_IDLE;
            r_sck_q   <= 1'b0;
            r_cnt     <= 3'd0;
            r_shift   <= 20'd0;
            r_addr    <= 24'd0;
            r_is_read <= 1'b0;
            r_wbuf    <= 4'd0;
            r_lo      <= 1'b0;
            r_sio     <= 4'd0;
            r_oe      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sck_q   <= i_mem_sck;
            r_cnt     <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_addr    <= w_addr_nx;
            r_is_read <= w_is_read_nx;
            r_wbuf    <= w_wbuf_nx;
            r_lo      <= w_lo_nx;
            r_sio     <= w_sio_nx;
            r_oe      <= w_oe_nx;
        end
    end

    // Storage is deliberately left out of reset so it maps onto RAM
    always_ff @(posedge i_mem_gck) begin
        if (w_mem_we) begin
            r_mem[r_addr[C_AW-1:0]] <= {r_wbuf, i_mem_sio};
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_shift_nx   = r_shift;
        w_addr_nx    = r_addr;
        w_is_read_nx = r_is_read;
        w_wbuf_nx    = r_wbuf;
        w_lo_nx      = r_lo;
        w_sio_nx     = r_sio;
        w_oe_nx      = r_oe;
        w_mem_we     = 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
        w_mode_nx    = r_mode;
`endif
        if (i_mem_cs) begin
            // Deselect wins over any edge seen in the same cycle
            w_state_nx = ST_IDLE;
            w_cnt_nx   = 3'd0;
            w_lo_nx    = 1'b0;
            w_sio_nx   = 4'd0;
            w_oe_nx    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_INSTR;
                    w_cnt_nx   = 3'd0;
                end
                ST_INSTR: begin
                    if (w_rise) begin
                        w_shift_nx = {r_shift[15:0], i_mem_sio};
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd1) begin
                            w_cnt_nx = 3'd0;
                            w_lo_nx  = 1'b0;
                            case (w_instr)
                                C_INSTR_READ: begin
                                    w_state_nx   = ST_ADDR;
                                    w_is_read_nx = 1'b1;
                                end
                                C_INSTR_WRITE: begin
                                    w_state_nx   = ST_ADDR;
                                    w_is_read_nx = 1'b0;
                                end
`ifdef IDLI_SQI_MEM_MODE_EN
                                C_INSTR_WRMR: w_state_nx = ST_MODE_WR;
                                C_INSTR_RDMR: w_state_nx = ST_MODE_RD;
`endif
                                default: w_state_nx = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        w_shift_nx = {r_shift[15:0], i_mem_sio};
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd5) begin
                            w_addr_nx  = {r_shift[19:0], i_mem_sio};
                            w_cnt_nx   = 3'd0;
                            w_state_nx = r_is_read ? ST_DUMMY : ST_WDATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (w_rise && r_cnt != 3'd2) begin
                        w_cnt_nx = r_cnt + 3'd1;
                    end else if (w_fall && r_cnt == 3'd2) begin
                        w_sio_nx   = w_rd_byte[7:4];
                        w_oe_nx    = 1'b1;
                        w_lo_nx    = 1'b1;
                        w_cnt_nx   = 3'd0;
                        w_state_nx = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (w_fall) begin
                        if (r_lo) begin
                            w_sio_nx  = w_rd_byte[3:0];
                            w_addr_nx = w_addr_inc;
                            w_lo_nx   = 1'b0;
                            if (w_byte_mode) begin
                                w_state_nx = ST_IGNORE;
                            end
                        end else begin
                            w_sio_nx = w_rd_byte[7:4];
                            w_lo_nx  = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_rise) begin
                        if (r_lo) begin
                            w_mem_we  = 1'b1;
                            w_addr_nx = w_addr_inc;
                            w_lo_nx   = 1'b0;
                            if (w_byte_mode) begin
                                w_state_nx = ST_IGNORE;
                            end
                        end else begin
                            w_wbuf_nx = i_mem_sio;
                            w_lo_nx   = 1'b1;
                        end
                    end
                end
                ST_IGNORE: begin
                    // Lets a byte-mode read hold its last nibble for a full sck cycle
                    if (w_fall) begin
                        w_oe_nx = 1'b0;
                    end
                end
`ifdef IDLI_SQI_MEM_MODE_EN
                ST_MODE_WR: begin
                    if (w_rise) begin
                        if (r_lo) begin
                            w_mode_nx  = {r_wbuf, i_mem_sio};
                            w_lo_nx    = 1'b0;
                            w_state_nx = ST_IGNORE;
                        end else begin
                            w_wbuf_nx = i_mem_sio;
                            w_lo_nx   = 1'b1;
                        end
                    end
                end
                ST_MODE_RD: begin
                    if (w_fall) begin
                        w_oe_nx  = 1'b1;
                        w_lo_nx  = ~r_lo;
                        w_sio_nx = r_lo ? r_mode[3:0] : r_mode[7:4];
                    end
                end
`endif
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign o_mem_sio    = r_sio;
    assign o_mem_sio_oe = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_mem_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_sqi_mem_m
// Brief    : Self-checking bench for idli_sqi_mem_m: transaction table plus
//            hand-written partial-write, ignore and async-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_mem_m;

    localparam int DEPTH = 1024;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] data;   // bytes left-justified: write data or expected read data
    } txn_t;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       cs;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       sio_oe;

    int         n_cmp;
    int         n_err;
    logic [3:0] exp_q [$];
    txn_t       tbl [8];

    idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
        .i_mem_gck    (clk),
        .i_mem_rst_n  (rst_n),
        .i_mem_sck    (sck),
        .i_mem_cs     (cs),
        .i_mem_sio    (sio_in),
        .o_mem_sio    (sio_out),
        .o_mem_sio_oe (sio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One sck period: rise sampled with nib, fall detected one gck later
    task automatic pulse(input logic [3:0] nib);
        @(negedge clk);
        sio_in = nib;
        sck    = 1'b1;
        @(negedge clk);
        sck    = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        check("oe_after_cs", {7'd0, sio_oe}, 8'h00);
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] instr, input logic [23:0] addr);
        pulse(instr[7:4]);
        pulse(instr[3:0]);
        for (int i = 5; i >= 0; i--) pulse(addr[i*4 +: 4]);
    endtask

    // Pops one expected nibble and compares it with the nibble on the bus
    task automatic pop_check(input string name);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %h expected none (scoreboard empty)", name, sio_out);
        end else begin
            e = exp_q.pop_front();
            check(name, {3'd0, sio_oe, sio_out}, {3'd0, 1'b1, e});
        end
    endtask

    task automatic run_txn(input txn_t t);
        logic [7:0] b;
        cs_low();
        send_hdr(t.wr ? 8'h02 : 8'h03, t.addr);
        if (t.wr) begin
            for (int j = 0; j < t.nbytes; j++) begin
                b = t.data[31-8*j -: 8];
                pulse(b[7:4]);
                pulse(b[3:0]);
            end
        end else begin
            for (int j = 0; j < t.nbytes; j++) begin
                b = t.data[31-8*j -: 8];
                exp_q.push_back(b[7:4]);
                exp_q.push_back(b[3:0]);
            end
            pulse(4'h0);
            pulse(4'h0);
            for (int k = 0; k < 2 * t.nbytes; k++) begin
                if (k > 0) pulse(4'h0);
                @(negedge clk);
                pop_check("rd_nibble");
            end
        end
        cs_high();
    endtask

    function automatic txn_t mk(input logic wr, input logic [23:0] a, input int n,
                                input logic [31:0] d);
        txn_t t;
        t.wr = wr;
        t.addr = a;
        t.nbytes = n;
        t.data = d;
        return t;
    endfunction

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        sck    = 1'b0;
        cs     = 1'b1;
        sio_in = 4'h0;

        tbl[0] = mk(1'b1, 24'h000010, 4, 32'hA53C7E01);
        tbl[1] = mk(1'b0, 24'h000010, 4, 32'hA53C7E01);
        tbl[2] = mk(1'b1, 24'(DEPTH-1), 2, 32'h11220000);
        tbl[3] = mk(1'b0, 24'h000000, 1, 32'h22000000);
        tbl[4] = mk(1'b0, 24'(DEPTH-1), 2, 32'h11220000);
        tbl[5] = mk(1'b1, 24'h000020, 2, 32'h55660000);
        tbl[6] = mk(1'b0, 24'h000020, 2, 32'h55660000);
        tbl[7] = mk(1'b0, 24'h000012, 2, 32'h7E010000);

        repeat (3) @(negedge clk);
        check("rst_sio", {4'd0, sio_out}, 8'h00);
        check("rst_oe", {7'd0, sio_oe}, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_oe", {7'd0, sio_oe}, 8'h00);

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Partial write: third nibble must be discarded on deselect
        cs_low();
        send_hdr(8'h02, 24'h000020);
        pulse(4'hF);
        pulse(4'h0);
        pulse(4'h9);
        cs_high();
        run_txn(mk(1'b0, 24'h000020, 2, 32'hF0660000));

        // Unknown instruction: no drive, no write
        cs_low();
        pulse(4'hF);
        pulse(4'hF);
        for (int i = 0; i < 16; i++) begin
            pulse(4'(i));
            @(negedge clk);
            check("ignore_oe", {7'd0, sio_oe}, 8'h00);
        end
        cs_high();
        run_txn(tbl[1]);

        // Asynchronous reset in the middle of a read burst
        cs_low();
        send_hdr(8'h03, 24'h000010);
        exp_q.push_back(4'hA);
        pulse(4'h0);
        pulse(4'h0);
        @(negedge clk);
        pop_check("pre_rst_nibble");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", {7'd0, sio_oe}, 8'h00);
        check("async_rst_sio", {4'd0, sio_out}, 8'h00);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(mk(1'b0, 24'h000010, 2, 32'hA53C0000));

`ifdef IDLI_SQI_MEM_MODE_EN
        cs_low();
        pulse(4'h0);
        pulse(4'h1);
        pulse(4'h8);
        pulse(4'h0);
        cs_high();
        run_txn(mk(1'b1, 24'h00001F, 2, 32'hAABB0000));
        cs_low();
        exp_q.push_back(4'h8);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h8);
        exp_q.push_back(4'h0);
        pulse(4'h0);
        pulse(4'h5);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) pulse(4'h0);
            @(negedge clk);
            pop_check("rdmr_nibble");
        end
        cs_high();
        run_txn(mk(1'b0, 24'h00001F, 1, 32'hAA000000));
        run_txn(mk(1'b0, 24'h000000, 1, 32'hBB000000));
`endif

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
